config_regs: RTL
================

Name: config_regs

Overview:
- CPU-facing register block that produces the cartridge configuration consumed by the PI-side config interface: sdram_switch, sdram_writable, dd_enabled, sram_enabled, flashram_enabled, flashram_read_mode, dd_offset and save_offset.
- CPU writes land in shadow registers.
- A commit request copies all shadows to the live outputs atomically, only while the PI is idle, so the mapping never changes mid-transaction.
- A timeout forces the commit if the PI stays busy too long.

Parameters:
- TIMEOUT_CYCLES, 4096: PENDING cycles with pi_busy high before a forced apply; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cpu_req  input  1  single-cycle bus request
- cpu_we  input  1  1 = write, 0 = read; qualified by cpu_req
- cpu_addr  input  2  register index
- cpu_wdata  input  32  write data
- cpu_rdata  output  32  read data, valid while cpu_ack is high
- cpu_ack  output  1  single-cycle acknowledge
- pi_busy  input  1  PI transaction in progress
- sdram_switch  output  1  live config
- sdram_writable  output  1  live config
- dd_enabled  output  1  live config
- sram_enabled  output  1  live config
- flashram_enabled  output  1  live config
- flashram_read_mode  output  1  live config
- dd_offset  output  26  live config
- save_offset  output  26  live config
- commit_done  output  1  one-cycle pulse after each apply

Behaviour:
- Register map:
  - 0 FLAGS: bits [5:0] = sdram_switch, sdram_writable, dd_enabled, sram_enabled, flashram_enabled, flashram_read_mode.
  - 1 DD_OFFSET: bits [25:0].
  - 2 SAVE_OFFSET: bits [25:0].
  - 3 COMMIT/STATUS:
    - Write with bit0 = 1 requests a commit.
    - Read returns: bit0 pending, bit1 locked, bit2 timeout, [15:8] commit_count.
  - Unused bits read 0 and ignore writes.
- Reads of 0–2 return the shadow values, not the live values.
- Reset values:
  - Shadow and live flags = 0,0,1,1,1,1 (bit0..bit5).
  - dd_offset = 26'h3BE_0000; save_offset = 26'h3FE_0000.
  - cpu_ack = 0; cpu_rdata = 0; commit_done = 0.
  - commit_count = 0; timeout flag = 0; lock = 0; state = IDLE.
- Bus handshake:
  - cpu_req sampled at edge N produces cpu_ack = 1 for exactly the following cycle, with cpu_rdata valid in that cycle.
  - A cpu_req asserted while cpu_ack is high is ignored (no ack).
  - Writes take effect at the same edge cpu_ack rises.
- FSM:
  - IDLE:
    - A commit write sets pending, clears the timeout flag, zeroes the timeout counter, and moves to PENDING.
    - A write to reg 3 with bit0 = 0 has no effect.
  - PENDING:
    - At each edge with pi_busy = 0: live <= shadow, commit_count++ (wraps 255→0), commit_done = 1 next cycle, go to IDLE.
    - At each edge with pi_busy = 1: counter++.
    - When TIMEOUT_CYCLES ≠ 0 and counter reaches TIMEOUT_CYCLES-1: apply as above regardless of pi_busy, and set the timeout flag.
  - Shadow writes during PENDING are accepted and included in that apply, since apply copies the shadow present at the apply edge.
  - A commit write during PENDING is acked and has no other effect; the counter is not restarted.
- Live outputs change only at an apply edge and never glitch between applies.
- Reset mid-PENDING drops the commit; all shadow and live values return to reset values.

Optional Feature:
- Macro CONFIG_LOCK_EN.
- When defined:
  - A commit write with bit31 = 1 sets lock after requesting the commit.
  - While locked, writes to regs 0–3 are acked but ignored.
  - Status bit1 reads 1; lock clears only on reset.
- When undefined: bit31 is ignored and status bit1 always reads 0.

Test Plan:
- Reset, then read all registers → FLAGS = 0x3C, reg1 = 0x3BE0000, reg2 = 0x3FE0000, status = 0; live outputs match; cpu_ack arrives exactly 1 cycle after each cpu_req.
- Write FLAGS = 0x03 and reg1 = 0x1000000 with pi_busy = 0 → live outputs unchanged; then commit → sdram_switch = 1, dd_offset = 0x1000000 within 2 cycles of the commit ack; commit_done pulses once; count = 1.
- Hold pi_busy = 1, commit, write reg2 = 0x2000000 during PENDING, release pi_busy after 50 cycles → status bit0 = 1 throughout; apply at the first idle edge; save_offset = 0x2000000.
- TIMEOUT_CYCLES = 16, pi_busy stuck high, commit → forced apply 16 cycles after entering PENDING; status = timeout 1, pending 0; the next commit clears the timeout flag.
- Perform 256 commits → count wraps to 0; assert reset mid-PENDING → no apply, defaults restored, commit_done stays 0.
- CONFIG_LOCK_EN: commit with bit31 set → locked = 1; a later FLAGS write is acked but the readback is unchanged.

Source files
------------

// File: rtl/config_regs.sv
// Cartridge configuration register block: CPU writes shadows, a commit copies them to the live outputs atomically while the PI is idle.
// Bus ack one cycle after request; apply on first idle PENDING edge or forced by timeout. Optional lock: CONFIG_LOCK_EN.
module config_regs #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        pi_busy,
    output logic        sdram_switch,
    output logic        sdram_writable,
    output logic        dd_enabled,
    output logic        sram_enabled,
    output logic        flashram_enabled,
    output logic        flashram_read_mode,
    output logic [25:0] dd_offset,
    output logic [25:0] save_offset,
    output logic        commit_done
);

    localparam logic [5:0]  FLAGS_RST = 6'h3C;
    localparam logic [25:0] DD_RST    = 26'h3BE_0000;
    localparam logic [25:0] SAVE_RST  = 26'h3FE_0000;
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES) - 32'd1;

    typedef enum logic {ST_IDLE, ST_PENDING} state_t;

    state_t      state_q, state_d;
    logic [5:0]  flags_sh_q, flags_sh_d, flags_lv_q, flags_lv_d;
    logic [25:0] dd_sh_q, dd_sh_d, dd_lv_q, dd_lv_d;
    logic [25:0] save_sh_q, save_sh_d, save_lv_q, save_lv_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tflag_q, tflag_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;

    logic        locked;
    logic        accept, wr_en, commit_wr;
    logic        timeout_hit, apply, forced, commit_start;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    // A request landing in the ack cycle is dropped so every ack maps to exactly one request.
    assign accept    = cpu_req && !ack_q;
    assign wr_en     = accept && cpu_we && !locked;
    assign commit_wr = wr_en && (cpu_addr == 2'd3) && cpu_wdata[0];

    assign unused_wdata = ^cpu_wdata[31:26];

`ifdef CONFIG_LOCK_EN
    logic lock_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else if (commit_wr && cpu_wdata[31]) begin
            lock_q <= 1'b1;
        end
    end
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (commit_wr) state_d = ST_PENDING;
            ST_PENDING: if (apply)     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
        apply        = 1'b0;
        forced       = 1'b0;
        commit_start = 1'b0;
        case (state_q)
            ST_IDLE:    commit_start = commit_wr;
            ST_PENDING: begin
                apply  = !pi_busy || timeout_hit;
                forced = pi_busy && timeout_hit;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (cpu_addr)
            2'd0: rd_mux = {26'd0, flags_sh_q};
            2'd1: rd_mux = {6'd0, dd_sh_q};
            2'd2: rd_mux = {6'd0, save_sh_q};
            2'd3: rd_mux = {16'd0, count_q, 5'd0, tflag_q, locked, (state_q == ST_PENDING)};
            default: ;
        endcase
    end

    always_comb begin
        flags_sh_d = flags_sh_q;
        dd_sh_d    = dd_sh_q;
        save_sh_d  = save_sh_q;
        if (wr_en) begin
            case (cpu_addr)
                2'd0:    flags_sh_d = cpu_wdata[5:0];
                2'd1:    dd_sh_d    = cpu_wdata[25:0];
                2'd2:    save_sh_d  = cpu_wdata[25:0];
                default: ;
            endcase
        end

        // Live copies the shadow registered before this edge, so a same-edge write waits for the next commit.
        flags_lv_d = apply ? flags_sh_q : flags_lv_q;
        dd_lv_d    = apply ? dd_sh_q    : dd_lv_q;
        save_lv_d  = apply ? save_sh_q  : save_lv_q;
        count_d    = count_q + {7'd0, apply};

        tflag_d = tflag_q;
        if (commit_start)
            tflag_d = 1'b0;
        else if (forced)
            tflag_d = 1'b1;

        cnt_d = cnt_q;
        if (commit_start)
            cnt_d = 32'd0;
        else if ((state_q == ST_PENDING) && pi_busy && !apply)
            cnt_d = cnt_q + 32'd1;

        ack_d   = accept;
        rdata_d = accept ? rd_mux : 32'd0;
        done_d  = apply;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_sh_q <= FLAGS_RST;
            dd_sh_q    <= DD_RST;
            save_sh_q  <= SAVE_RST;
            flags_lv_q <= FLAGS_RST;
            dd_lv_q    <= DD_RST;
            save_lv_q  <= SAVE_RST;
            count_q    <= 8'd0;
            cnt_q      <= 32'd0;
            tflag_q    <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            flags_sh_q <= flags_sh_d;
            dd_sh_q    <= dd_sh_d;
            save_sh_q  <= save_sh_d;
            flags_lv_q <= flags_lv_d;
            dd_lv_q    <= dd_lv_d;
            save_lv_q  <= save_lv_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            tflag_q    <= tflag_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
        end
    end

    assign cpu_ack            = ack_q;
    assign cpu_rdata          = rdata_q;
    assign commit_done        = done_q;
    assign sdram_switch       = flags_lv_q[0];
    assign sdram_writable     = flags_lv_q[1];
    assign dd_enabled         = flags_lv_q[2];
    assign sram_enabled       = flags_lv_q[3];
    assign flashram_enabled   = flags_lv_q[4];
    assign flashram_read_mode = flags_lv_q[5];
    assign dd_offset          = dd_lv_q;
    assign save_offset        = save_lv_q;

endmodule
